// File: rtl/port_bank_pkg.sv
// port_bank_pkg: shared port configuration record, write FSM states and limits for port_bank.
package port_bank_pkg;

    localparam int IO_PORT_MAX = 8;

    typedef struct packed {
        logic [15:0] mask;
        logic [15:0] match;
        logic [7:0]  rst;
    } port_cfg_t;

    typedef enum logic {WR_IDLE, WR_DONE} port_wr_state_t;

    function automatic port_cfg_t port_cfg(input logic [15:0] mask, input logic [15:0] match,
                                           input logic [7:0] rst);
        port_cfg_t c;
        c.mask  = mask;
        c.match = match;
        c.rst   = rst;
        return c;
    endfunction

endpackage

// File: rtl/port_bank_decode.sv
// port_bank_decode: single mask/match address comparator for one I/O port.
module port_bank_decode
    import port_bank_pkg::*;
#(
    parameter port_cfg_t CFG = '0
) (
    input  logic        i_en,
    input  logic        i_ioreq,
    input  logic [15:0] i_a,
    output logic        o_hit
);

    assign o_hit = i_en & i_ioreq & ((i_a & CFG.mask) == CFG.match);

endmodule

// File: rtl/port_bank.sv
// port_bank: bank of write-latched Z80 I/O port registers with lock bit.
// Define PORT_BANK_READBACK_EN to build the registered read-back path.
module port_bank
    import port_bank_pkg::*;
#(
    parameter int                   NPORTS     = 4,
    parameter int                   DW         = 8,
    parameter logic [NPORTS*16-1:0] PORT_MASK  = {4{16'h8002}},
    parameter logic [NPORTS*16-1:0] PORT_MATCH = {4{16'h0000}},
    parameter logic [NPORTS*8-1:0]  PORT_RST   = {4{8'h00}},
    parameter int                   LOCK_PORT  = 0,
    parameter int                   LOCK_BIT   = 5
) (
    input  logic                 clk28,
    input  logic                 rst,
    input  logic [15:0]          bus_a,
    input  logic [7:0]           bus_d,
    input  logic                 bus_ioreq,
    input  logic                 bus_rd,
    input  logic                 bus_wr,
    input  logic                 clkcpu_ck,
    input  logic [NPORTS-1:0]    en,
    input  logic                 lock_ovr,
    output logic [NPORTS*DW-1:0] regs,
    output logic [NPORTS-1:0]    wr_stb,
    output logic                 locked,
    output logic [7:0]           d_out,
    output logic                 d_out_active
);

    logic [NPORTS-1:0]    w_hit;
    logic [NPORTS-1:0]    w_take;
    logic                 w_commit;
    logic                 w_lock_take;
    logic                 w_unused;
    port_wr_state_t       r_state;
    logic [NPORTS*DW-1:0] r_regs;
    logic [NPORTS-1:0]    r_wr_stb;
    logic                 r_locked;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        localparam port_cfg_t CFG = port_cfg(PORT_MASK[i*16 +: 16], PORT_MATCH[i*16 +: 16],
                                             PORT_RST[i*8 +: 8]);
        port_bank_decode #(.CFG(CFG)) u_dec (
            .i_en    (en[i]),
            .i_ioreq (bus_ioreq),
            .i_a     (bus_a),
            .o_hit   (w_hit[i])
        );
        assign w_take[i] = w_hit[i] & !(i == LOCK_PORT && r_locked && !lock_ovr);
    end

    if (LOCK_PORT < NPORTS) begin : g_lock
        assign w_lock_take = w_take[LOCK_PORT];
    end else begin : g_nolock
        assign w_lock_take = 1'b0;
    end

    // A whole IO cycle yields at most one commit; DONE holds until ioreq drops.
    assign w_commit = r_state == WR_IDLE && bus_ioreq && bus_wr && clkcpu_ck && |w_hit;
    assign w_unused = ^{bus_rd, bus_d};

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state  <= WR_IDLE;
            r_wr_stb <= '0;
            r_locked <= 1'b0;
            for (int i = 0; i < NPORTS; i++) r_regs[i*DW +: DW] <= PORT_RST[i*8 +: DW];
        end else begin
            r_state  <= w_commit ? WR_DONE : (bus_ioreq ? r_state : WR_IDLE);
            r_wr_stb <= w_commit ? w_take : '0;
            for (int i = 0; i < NPORTS; i++)
                if (w_commit && w_take[i]) r_regs[i*DW +: DW] <= bus_d[DW-1:0];
            // Lock is sticky: an override write may rewrite the port but never unlocks it.
            if (w_commit && w_lock_take) r_locked <= r_locked | bus_d[LOCK_BIT];
        end
    end

    assign regs   = r_regs;
    assign wr_stb = r_wr_stb;
    assign locked = r_locked;

`ifdef PORT_BANK_READBACK_EN
    logic [7:0] w_rd_data;
    logic       w_rd_hit;
    logic [7:0] r_d_out;
    logic       r_active;

    assign w_rd_hit = bus_ioreq & bus_rd & |w_hit;

    always_comb begin
        w_rd_data = 8'hFF;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (w_hit[i]) w_rd_data[DW-1:0] = r_regs[i*DW +: DW];
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_d_out  <= 8'hFF;
            r_active <= 1'b0;
        end else begin
            r_d_out  <= w_rd_hit ? w_rd_data : 8'hFF;
            r_active <= w_rd_hit;
        end
    end

    assign d_out        = r_d_out;
    assign d_out_active = r_active;
`else
    assign d_out        = 8'hFF;
    assign d_out_active = 1'b0;
`endif

endmodule
